// File: rtl/rom_squ_wave.sv
`default_nettype none
// ============================================================================
// Module      : rom_squ_wave
// Description : Read-only square-wave lookup table. Holds one period of a
//               square wave: the first HIGH_WORDS words are all ones and the
//               remaining words are all zeros. Read data is registered, so
//               there is no combinational path from addr to rd_data.
//
// Parameters  : ADDR_WIDTH - address width; the table depth is 2**ADDR_WIDTH
//               DATA_WIDTH - word width
//               HIGH_WORDS - number of leading full-scale words (duty cycle).
//                            Values <= 0 give an all-zero table; values
//                            >= 2**ADDR_WIDTH give an all-ones table.
//
// Ports       : clk     - in,  1 bit,        rising-edge clock
//               rst     - in,  1 bit,        asynchronous reset, active LOW
//               addr    - in,  ADDR_WIDTH,   read address, sampled every edge
//               rd_data - out, DATA_WIDTH,   registered read data
//
// Build macro : ROM_SQU_WAVE_OUTPUT_REG_EN
//               Defined   -> second output register, read latency 2 clk
//               Undefined -> single output register, read latency 1 clk
//
// Revision    : 1.0 - initial release
// ============================================================================
module rom_squ_wave #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int HIGH_WORDS = 2 ** (ADDR_WIDTH - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int c_depth = 2 ** ADDR_WIDTH;

  // Clamp the duty cycle into [0, depth] so out-of-range settings simply
  // saturate to an all-zero or all-ones table.
  localparam int c_high = (HIGH_WORDS < 0)       ? 0       :
                          (HIGH_WORDS > c_depth) ? c_depth : HIGH_WORDS;

  localparam logic [DATA_WIDTH-1:0] c_word_hi = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] c_word_lo = {DATA_WIDTH{1'b0}};

  // --------------------------------------------------------------------------
  // Table contents: constant-driven, fixed at elaboration. Being pure
  // constants, they are untouched by reset. The address is exactly
  // ADDR_WIDTH bits wide, so every address is naturally taken modulo depth.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_rom [c_depth];

  generate
    for (genvar gi = 0; gi < c_depth; gi++) begin : g_rom
      assign w_rom[gi] = (gi < c_high) ? c_word_hi : c_word_lo;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // First read stage: one lookup every cycle, no enable.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_rom[addr];
    end
  end

`ifdef ROM_SQU_WAVE_OUTPUT_REG_EN
  // --------------------------------------------------------------------------
  // Optional retiming stage. It is cleared with the first stage, so the first
  // edge after reset release still presents zero on rd_data.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_data_q2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_q2 <= '0;
    end else begin
      r_data_q2 <= r_data;
    end
  end

  assign rd_data = r_data_q2;
`else
  assign rd_data = r_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_squ_wave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rom_squ_wave
// Description : Self-checking bench for rom_squ_wave at default parameters.
//               Expected words are pushed to a queue as each address is
//               sampled and popped when the matching output is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_squ_wave;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 8;
  localparam int HIGH_WORDS = 512;
  localparam int DEPTH      = 1024;
`ifdef ROM_SQU_WAVE_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] exp_q[$];

  rom_squ_wave #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .HIGH_WORDS(HIGH_WORDS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Reference square wave: full scale below HIGH_WORDS, zero above.
  function automatic logic [DATA_WIDTH-1:0] model(input int a);
    return ((a % DEPTH) < HIGH_WORDS) ? 8'hFF : 8'h00;
  endfunction

  // After reset the pipeline holds zeros; one zero per stage beyond the first.
  task automatic prime_pipe();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back(8'h00);
  endtask

  // Present an address at the falling edge, let it be sampled, record the
  // expected word, then settle 1 ns past the rising edge.
  task automatic drive_edge(input int a);
    @(negedge clk);
    addr = a[ADDR_WIDTH-1:0];
    @(posedge clk);
    exp_q.push_back(model(a));
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    addr = 10'd5;
    #2;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_async rd_data=%h expected=%h", rd_data, 8'h00);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_held rd_data=%h expected=%h", rd_data, 8'h00);
    end
    prime_pipe();
  endtask

  task automatic test_release();
    logic [DATA_WIDTH-1:0] e;
    @(negedge clk);
    rst  = 1'b1;
    addr = 10'd0;
    @(posedge clk);
    exp_q.push_back(model(0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL release_first rd_data=%h expected=%h", rd_data, e);
    end
  endtask

  task automatic test_points();
    int pts[6] = '{0, 511, 512, 1023, 511, 512};
    logic [DATA_WIDTH-1:0] e;
    foreach (pts[i]) begin
      drive_edge(pts[i]);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL points addr=%0d rd_data=%h expected=%h", pts[i], rd_data, e);
      end
    end
  endtask

  task automatic test_sweep();
    logic [DATA_WIDTH-1:0] e;
    int ones_first;
    int zeros_second;
    int pos;
    ones_first   = 0;
    zeros_second = 0;
    for (int idx = 0; idx < DEPTH + LAT - 1; idx++) begin
      drive_edge(idx % DEPTH);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL sweep idx=%0d rd_data=%h expected=%h", idx, rd_data, e);
      end
      pos = idx - (LAT - 1);
      if (pos >= 0 && pos < HIGH_WORDS && rd_data === 8'hFF) ones_first++;
      if (pos >= HIGH_WORDS && pos < DEPTH && rd_data === 8'h00) zeros_second++;
    end
    checks++;
    if (ones_first !== 512) begin
      errors++;
      $display("FAIL sweep_ones count=%0d expected=%0d", ones_first, 512);
    end
    checks++;
    if (zeros_second !== 512) begin
      errors++;
      $display("FAIL sweep_zeros count=%0d expected=%0d", zeros_second, 512);
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_WIDTH-1:0] e;
    int a;
    for (int i = 0; i < 16; i++) begin
      a = (i % 2 == 0) ? 511 : 512;
      if (i == 7) a = 1023;
      if (i == 8) a = 0;
      drive_edge(a);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL back_to_back addr=%0d rd_data=%h expected=%h", a, rd_data, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [DATA_WIDTH-1:0] e;
    for (int a = 90; a <= 100; a++) begin
      drive_edge(a);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL mid_sweep addr=%0d rd_data=%h expected=%h", a, rd_data, e);
      end
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_clear rd_data=%h expected=%h", rd_data, 8'h00);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_held rd_data=%h expected=%h", rd_data, 8'h00);
    end
    prime_pipe();
    @(negedge clk);
    rst  = 1'b1;
    addr = 10'd100;
    @(posedge clk);
    exp_q.push_back(model(100));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL mid_reset_resume rd_data=%h expected=%h", rd_data, e);
    end
    drive_edge(101);
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== e) begin
      errors++;
      $display("FAIL mid_reset_next rd_data=%h expected=%h", rd_data, e);
    end
  endtask

`ifdef ROM_SQU_WAVE_OUTPUT_REG_EN
  task automatic test_step();
    logic [DATA_WIDTH-1:0] e;
    repeat (3) begin
      drive_edge(600);
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin
        errors++;
        $display("FAIL step_hold rd_data=%h expected=%h", rd_data, e);
      end
    end
    drive_edge(0);
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== 8'h00 || e !== 8'h00) begin
      errors++;
      $display("FAIL step_edge1 rd_data=%h expected=%h", rd_data, 8'h00);
    end
    drive_edge(0);
    e = exp_q.pop_front();
    checks++;
    if (rd_data !== 8'hFF || e !== 8'hFF) begin
      errors++;
      $display("FAIL step_edge2 rd_data=%h expected=%h", rd_data, 8'hFF);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_points();
    test_sweep();
    test_back_to_back();
    test_mid_reset();
`ifdef ROM_SQU_WAVE_OUTPUT_REG_EN
    test_step();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_squ_wave.md
ROM_SQU_WAVE -- requirements
Module: rom_squ_wave

Interface
- REQ-001: The block SHALL have parameter ADDR_WIDTH, default 10, giving the address bus width and a depth of 2**ADDR_WIDTH words.
- REQ-002: The block SHALL have parameter DATA_WIDTH, default 8, giving the word width.
- REQ-003: The block SHALL have parameter HIGH_WORDS, default 2**(ADDR_WIDTH-1), giving the number of leading words at full scale (duty cycle).
- REQ-004: The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
- REQ-005: The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset (0 = reset asserted).
- REQ-006: The block SHALL have port addr, input, ADDR_WIDTH bits, the read address, sampled every rising clk edge.
- REQ-007: The block SHALL have port rd_data, output, DATA_WIDTH bits, the registered read data.

Function
- REQ-008: The block SHALL be a read-only table of 2**ADDR_WIDTH words of DATA_WIDTH bits holding one period of a square wave, with no write port.
- REQ-009: The word at addresses 0 to HIGH_WORDS-1 SHALL be all ones (0xFF at default width).
- REQ-010: The word at addresses HIGH_WORDS to 2**ADDR_WIDTH-1 SHALL be all zeros.
- REQ-011: HIGH_WORDS values of 0 or greater than or equal to 2**ADDR_WIDTH SHALL give an all-zero or all-ones table respectively, with no error.
- REQ-012: Table contents SHALL be fixed at elaboration, with no external init file required.
- REQ-013: The block SHALL read every cycle; there is no enable or strobe input.
- REQ-014: Read latency SHALL be 1 clk: rd_data after edge N equals the table word at the addr sampled at edge N.
- REQ-015: Addresses SHALL be used modulo 2**ADDR_WIDTH, so wrap-around from 2**ADDR_WIDTH-1 to 0 needs no special handling.
- REQ-016: A sequential address sweep SHALL produce HIGH_WORDS consecutive all-ones outputs followed by all-zeros outputs, repeating per period.
- REQ-017: rd_data SHALL change only at rising clk edges or on reset assertion; it SHALL NOT have a combinational path from addr.

Reset
- REQ-018: While rst=0, every output register SHALL be all zeros, cleared immediately and independent of clk.
- REQ-019: After rst deasserts, the first rising edge SHALL load the word for the addr present at that edge.
- REQ-020: Reset asserted mid-sweep SHALL clear rd_data at once, and reads SHALL resume after deassert with no stale data.
- REQ-021: Table contents SHALL be unaffected by reset.

Configuration
- REQ-022: The macro ROM_SQU_WAVE_OUTPUT_REG_EN SHALL, when defined, add a second output register stage, making read latency 2 clk.
- REQ-023: The extra stage from REQ-022 SHALL also be cleared to zero by reset, and rd_data SHALL show zero for the first edge after deassert.
- REQ-024: When ROM_SQU_WAVE_OUTPUT_REG_EN is undefined, the block SHALL use one register stage with latency 1, as in REQ-014.
- REQ-025: Table contents and addressing SHALL be identical with or without ROM_SQU_WAVE_OUTPUT_REG_EN.

Verification
- REQ-026: The bench SHALL check: rst=0 with addr=5 -> rd_data=0x00 during reset, without waiting for a clock edge.
- REQ-027: The bench SHALL check: after deassert, addr=0 at edge N -> rd_data=0xFF after edge N; addr=511 -> 0xFF.
- REQ-028: The bench SHALL check: addr=512 -> 0x00 after one edge; addr=1023 -> 0x00.
- REQ-029: The bench SHALL check: a sweep of addr 0..1023 one per clk -> exactly 512 words of 0xFF then 512 of 0x00, each delayed by 1 clk.
- REQ-030: The bench SHALL check: rst pulsed low at addr=100 mid-sweep -> rd_data=0x00 immediately, then 0xFF one edge after release.
- REQ-031: The bench SHALL check: with ROM_SQU_WAVE_OUTPUT_REG_EN defined, a step of addr from 600 to 0 -> rd_data goes 0x00 to 0xFF exactly 2 edges later.
